// File: rtl/ingress_stall_fifo.sv
// Dual-channel ingress buffer: two independent circular FIFOs feeding two
// stallable pipelines, with per-channel flush and saturating drop counters.

module ingress_stall_fifo_chan #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     flush,
    input  logic                     stall,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [LW-1:0]     count;
    logic [7:0]        drops;
    logic              push;
    logic              pop;

    // Ready/valid come from registered occupancy only, so stall never
    // reaches the producer combinationally.
    always_comb begin
        in_ready  = (count != LW'(DEPTH));
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && !stall;
        out_data  = mem[rd_ptr];
        level     = count;
        drop_cnt  = drops;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            drops  <= '0;
        end else begin
            if (in_valid && !in_ready && drops != '1)
                drops <= drops + 8'd1;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop)
                    count <= count + LW'(1);
                else if (pop && !push)
                    count <= count - LW'(1);
            end
        end
    end

    // Storage is not reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset)
            mem[wr_ptr] <= in_data;
    end
endmodule

module ingress_stall_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        ch1_in_data,
    input  logic [DATA_W-1:0]        ch2_in_data,
    input  logic [1:0]               in_valid,
    input  logic                     flush_1,
    input  logic                     flush_2,
    input  logic                     stall_1,
    input  logic                     stall_2,
    output logic [1:0]               in_ready,
    output logic [DATA_W-1:0]        ch1_out_data,
    output logic [DATA_W-1:0]        ch2_out_data,
    output logic [1:0]               out_valid,
    output logic [$clog2(DEPTH):0]   level_1,
    output logic [$clog2(DEPTH):0]   level_2,
    output logic [7:0]               drop_cnt_1,
    output logic [7:0]               drop_cnt_2
);
    ingress_stall_fifo_chan #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ch1 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (ch1_in_data),
        .in_valid  (in_valid[0]),
        .flush     (flush_1),
        .stall     (stall_1),
        .in_ready  (in_ready[0]),
        .out_data  (ch1_out_data),
        .out_valid (out_valid[0]),
        .level     (level_1),
        .drop_cnt  (drop_cnt_1)
    );

    ingress_stall_fifo_chan #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ch2 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (ch2_in_data),
        .in_valid  (in_valid[1]),
        .flush     (flush_2),
        .stall     (stall_2),
        .in_ready  (in_ready[1]),
        .out_data  (ch2_out_data),
        .out_valid (out_valid[1]),
        .level     (level_2),
        .drop_cnt  (drop_cnt_2)
    );
endmodule

// File: tb/tb_ingress_stall_fifo.sv
// Directed + short random bench for ingress_stall_fifo with a per-channel
// queue scoreboard compared after every clock edge.

module tb_ingress_stall_fifo;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] ch1_in_data;
    logic [DATA_W-1:0] ch2_in_data;
    logic [1:0]        in_valid;
    logic              flush_1;
    logic              flush_2;
    logic              stall_1;
    logic              stall_2;
    logic [1:0]        in_ready;
    logic [DATA_W-1:0] ch1_out_data;
    logic [DATA_W-1:0] ch2_out_data;
    logic [1:0]        out_valid;
    logic [LW-1:0]     level_1;
    logic [LW-1:0]     level_2;
    logic [7:0]        drop_cnt_1;
    logic [7:0]        drop_cnt_2;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] q2[$];
    int                d1 = 0;
    int                d2 = 0;

    ingress_stall_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ch1_in_data  (ch1_in_data),
        .ch2_in_data  (ch2_in_data),
        .in_valid     (in_valid),
        .flush_1      (flush_1),
        .flush_2      (flush_2),
        .stall_1      (stall_1),
        .stall_2      (stall_2),
        .in_ready     (in_ready),
        .ch1_out_data (ch1_out_data),
        .ch2_out_data (ch2_out_data),
        .out_valid    (out_valid),
        .level_1      (level_1),
        .level_2      (level_2),
        .drop_cnt_1   (drop_cnt_1),
        .drop_cnt_2   (drop_cnt_2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, using only bench-side state and the driven inputs.
    task automatic model_edge();
        bit full1, full2;
        full1 = (q1.size() == DEPTH);
        full2 = (q2.size() == DEPTH);
        if (in_valid[0] && full1 && d1 < 255) d1++;
        if (in_valid[1] && full2 && d2 < 255) d2++;
        if (flush_1) q1.delete();
        else begin
            if (q1.size() != 0 && !stall_1) void'(q1.pop_front());
            if (in_valid[0] && !full1) q1.push_back(ch1_in_data);
        end
        if (flush_2) q2.delete();
        else begin
            if (q2.size() != 0 && !stall_2) void'(q2.pop_front());
            if (in_valid[1] && !full2) q2.push_back(ch2_in_data);
        end
    endtask

    task automatic compare_all();
        chk("in_ready",   32'(in_ready),   32'({q2.size() != DEPTH, q1.size() != DEPTH}));
        chk("out_valid",  32'(out_valid),  32'({q2.size() != 0, q1.size() != 0}));
        chk("level_1",    32'(level_1),    32'(q1.size()));
        chk("level_2",    32'(level_2),    32'(q2.size()));
        chk("drop_cnt_1", 32'(drop_cnt_1), 32'(d1));
        chk("drop_cnt_2", 32'(drop_cnt_2), 32'(d2));
        if (q1.size() != 0) chk("ch1_out_data", ch1_out_data, q1[0]);
        if (q2.size() != 0) chk("ch2_out_data", ch2_out_data, q2[0]);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                         input logic s1, input logic s2, input logic f1, input logic f2);
        in_valid    = v;
        ch1_in_data = a;
        ch2_in_data = b;
        stall_1     = s1;
        stall_2     = s2;
        flush_1     = f1;
        flush_2     = f2;
    endtask

    initial begin
        reset = 1'b1;
        drive(2'b00, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #7;
        compare_all();
        chk("reset_in_ready",  32'(in_ready),  32'h3);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        #5 reset = 1'b0;
        @(posedge clk); #1;

        // Fill channel 1 while stalled, then overflow by one.
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 32'hA0 + 32'(i), '0, 1'b1, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        drive(2'b01, 32'hA4, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("full_ready0", 32'(in_ready[0]), 32'h0);
        chk("full_level1", 32'(level_1),     32'h4);
        chk("full_drop1",  32'(drop_cnt_1),  32'h1);
        chk("full_ch2_idle", 32'(level_2),   32'h0);

        // Release stall: drain A0..A3 in order.
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i < 4) chk("drain_head", ch1_out_data, 32'hA0 + 32'(i));
            cyc();
        end
        chk("drain_level1", 32'(level_1),      32'h0);
        chk("drain_valid0", 32'(out_valid[0]), 32'h0);

        // Empty channel with stall toggling: no underflow.
        drive(2'b00, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();

        // Channel 2 at level 2 with simultaneous push/pop across wrap.
        for (int i = 0; i < 2; i++) begin
            drive(2'b10, '0, 32'hB0 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b0);
            cyc();
        end
        for (int i = 0; i < 10; i++) begin
            drive(2'b10, '0, 32'hB2 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            chk("steady_head2", ch2_out_data, 32'hB0 + 32'(i));
            cyc();
            chk("steady_level2", 32'(level_2), 32'h2);
        end

        // Level 3 then flush with a same-cycle push of 0x55.
        drive(2'b10, '0, 32'hC0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("pre_flush_level2", 32'(level_2), 32'h3);
        drive(2'b10, '0, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("flush_level2", 32'(level_2),      32'h0);
        chk("flush_valid1", 32'(out_valid[1]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc();
            chk("no_55_valid1", 32'(out_valid[1]), 32'h0);
        end

        // Saturate the channel 1 drop counter.
        for (int i = 0; i < 304; i++) begin
            drive(2'b01, 32'h100 + 32'(i), '0, 1'b1, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        chk("drop1_sat", 32'(drop_cnt_1), 32'hFF);
        chk("drop2_untouched", 32'(drop_cnt_2), 32'h0);

        // Flush channel 1 keeps drop count.
        drive(2'b00, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();
        chk("flush1_keeps_drop", 32'(drop_cnt_1), 32'hFF);

        // Mixed random traffic on both channels.
        for (int i = 0; i < 200; i++) begin
            drive(2'($urandom_range(0, 3)), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0));
            cyc();
        end

        // Burst on both channels, then asynchronous reset mid-cycle.
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 32'hD0 + 32'(i), 32'hE0 + 32'(i), 1'b1, 1'b1, 1'b0, 1'b0);
            cyc();
        end
        #2 reset = 1'b1;
        #1;
        q1.delete();
        q2.delete();
        d1 = 0;
        d2 = 0;
        chk("async_in_ready",  32'(in_ready),   32'h3);
        chk("async_out_valid", 32'(out_valid),  32'h0);
        chk("async_level1",    32'(level_1),    32'h0);
        chk("async_level2",    32'(level_2),    32'h0);
        chk("async_drop1",     32'(drop_cnt_1), 32'h0);
        drive(2'b00, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        cyc();
        drive(2'b10, '0, 32'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("post_reset_head2", ch2_out_data, 32'hF0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not finish within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
